// File: rtl/irq_trap_scheduler.sv
// irq_trap_scheduler: picks the highest-priority eligible interrupt, latches
// its cause, and raises a registered trap request toward the Memory stage.
// After each taken trap or xRET, arbitration stays blocked for HOLDOFF cycles
// so that updated STATUS state can settle.
// Optional WFI wake output is built when IRQ_TRAP_SCHEDULER_WFI_EN is defined.
module irq_trap_scheduler #(
  parameter int NIRQ        = 12,
  parameter int CAUSEW      = 4,
  parameter int S_SUPPORTED = 1,
  parameter int HOLDOFF     = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NIRQ-1:0]   MIP_REGW,
  input  logic [NIRQ-1:0]   MIE_REGW,
  input  logic [NIRQ-1:0]   MIDELEG_REGW,
  input  logic              STATUS_MIE,
  input  logic              STATUS_SIE,
  input  logic [1:0]        PrivilegeModeW,
  input  logic              StallW,
  input  logic              ExceptionM,
  input  logic              TrapAckM,
  input  logic              mretM,
  input  logic              sretM,
`ifdef IRQ_TRAP_SCHEDULER_WFI_EN
  input  logic              WfiM,
  output logic              WfiWakeM,
`endif
  output logic              IntReqM,
  output logic [CAUSEW-1:0] IntCauseM,
  output logic              IntDelegateM,
  output logic              SchedBusyM
);

  typedef enum logic [1:0] {IDLE, REQ, HOLD} schedStateT;

  localparam logic [2:0]      HOLD_LOAD  = 3'(HOLDOFF);
  localparam logic [NIRQ-1:0] DELEG_MASK = (S_SUPPORTED != 0) ? {NIRQ{1'b1}} : {NIRQ{1'b0}};

  schedStateT        r_state;
  schedStateT        w_nextState;
  logic [2:0]        r_count;
  logic [2:0]        w_nextCount;
  logic [CAUSEW-1:0] r_cause;
  logic [CAUSEW-1:0] w_nextCause;
  logic              r_deleg;
  logic              w_nextDeleg;
  logic              r_intReq;
  logic              r_busy;

  logic [NIRQ-1:0]   w_pend;
  logic [NIRQ-1:0]   w_deleg;
  logic [NIRQ-1:0]   w_eligible;
  logic              w_privM;
  logic              w_privS;
  logic              w_privU;
  logic              w_nondelegOk;
  logic              w_delegOk;
  logic              w_xret;
  logic              w_selValid;
  logic [CAUSEW-1:0] w_selIdx;
  logic              w_selDeleg;
  logic              w_latchedElig;

  // Without S-mode nothing can be delegated, so the delegation CSR is masked off.
  assign w_pend  = MIP_REGW & MIE_REGW;
  assign w_deleg = MIDELEG_REGW & DELEG_MASK;
  assign w_privM = (PrivilegeModeW == 2'b11);
  assign w_privS = (PrivilegeModeW == 2'b01);
  assign w_privU = (PrivilegeModeW == 2'b00);
  assign w_xret  = mretM | sretM;

  // M-targeted interrupts are always taken from a lower mode; in M they need MIE.
  // S-targeted interrupts are taken from U, or from S with SIE, never from M.
  assign w_nondelegOk = ~w_privM | STATUS_MIE;
  assign w_delegOk    = w_privU | (w_privS & STATUS_SIE);
  assign w_eligible   = w_pend & ((~w_deleg & {NIRQ{w_nondelegOk}}) |
                                  ( w_deleg & {NIRQ{w_delegOk}}));

  // Priority select: later assignments win, so the lowest-priority candidates go first.
  always_comb begin
    w_selValid = 1'b0;
    w_selIdx   = '0;
    w_selDeleg = 1'b0;
    for (int i = 12; i < NIRQ; i++) begin
      if (w_eligible[i]) begin
        w_selValid = 1'b1;
        w_selIdx   = CAUSEW'(i);
        w_selDeleg = w_deleg[i];
      end
    end
    if (w_eligible[5]) begin
      w_selValid = 1'b1;
      w_selIdx   = CAUSEW'(5);
      w_selDeleg = w_deleg[5];
    end
    if (w_eligible[1]) begin
      w_selValid = 1'b1;
      w_selIdx   = CAUSEW'(1);
      w_selDeleg = w_deleg[1];
    end
    if (w_eligible[9]) begin
      w_selValid = 1'b1;
      w_selIdx   = CAUSEW'(9);
      w_selDeleg = w_deleg[9];
    end
    if (w_eligible[7]) begin
      w_selValid = 1'b1;
      w_selIdx   = CAUSEW'(7);
      w_selDeleg = w_deleg[7];
    end
    if (w_eligible[3]) begin
      w_selValid = 1'b1;
      w_selIdx   = CAUSEW'(3);
      w_selDeleg = w_deleg[3];
    end
    if (w_eligible[11]) begin
      w_selValid = 1'b1;
      w_selIdx   = CAUSEW'(11);
      w_selDeleg = w_deleg[11];
    end
  end

  // Re-check the eligibility of the cause we already latched, for withdrawal.
  always_comb begin
    w_latchedElig = 1'b0;
    for (int i = 0; i < NIRQ; i++) begin
      if (r_cause == CAUSEW'(i)) begin
        w_latchedElig = w_eligible[i];
      end
    end
  end

  // Next-state logic; a stall freezes everything by keeping the current values.
  always_comb begin
    w_nextState = r_state;
    w_nextCount = r_count;
    w_nextCause = r_cause;
    w_nextDeleg = r_deleg;
    if (!StallW) begin
      case (r_state)
        IDLE: begin
          if (w_xret) begin
            w_nextState = HOLD;
            w_nextCount = HOLD_LOAD;
          end else if (w_selValid && !ExceptionM) begin
            w_nextState = REQ;
            w_nextCause = w_selIdx;
            w_nextDeleg = w_selDeleg;
          end
        end
        REQ: begin
          if (TrapAckM && !ExceptionM) begin
            w_nextState = HOLD;
            w_nextCount = HOLD_LOAD;
          end else if (!TrapAckM && !w_latchedElig) begin
            w_nextState = IDLE;
          end
        end
        HOLD: begin
          if (w_xret) begin
            w_nextCount = HOLD_LOAD;
          end else if (r_count <= 3'd1) begin
            w_nextState = IDLE;
            w_nextCount = 3'd0;
          end else begin
            w_nextCount = r_count - 3'd1;
          end
        end
        default: begin
          w_nextState = IDLE;
          w_nextCount = 3'd0;
        end
      endcase
    end
  end

  // State, cause and registered outputs; reset drops any pending request at once.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state  <= IDLE;
      r_count  <= 3'd0;
      r_cause  <= '0;
      r_deleg  <= 1'b0;
      r_intReq <= 1'b0;
      r_busy   <= 1'b0;
    end else if (!StallW) begin
      r_state  <= w_nextState;
      r_count  <= w_nextCount;
      r_cause  <= w_nextCause;
      r_deleg  <= w_nextDeleg;
      r_intReq <= (w_nextState == REQ);
      r_busy   <= (w_nextState != IDLE);
    end
  end

  assign IntReqM      = r_intReq;
  assign IntCauseM    = r_cause;
  assign IntDelegateM = r_deleg;
  assign SchedBusyM   = r_busy;

`ifdef IRQ_TRAP_SCHEDULER_WFI_EN
  logic r_wfiWake;

  // Wake ignores stall and global enables so a stalled WFI can always resume.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wfiWake <= 1'b0;
    end else begin
      r_wfiWake <= WfiM & (|w_pend);
    end
  end

  assign WfiWakeM = r_wfiWake;
`endif

endmodule

// File: tb/tb_irq_trap_scheduler.sv
// Testbench for irq_trap_scheduler: directed vectors plus a per-cycle
// comparison against a behavioural model of the scheduling rules.
module tb_irq_trap_scheduler;

  localparam int NIRQ        = 12;
  localparam int CAUSEW      = 4;
  localparam int S_SUPPORTED = 1;
  localparam int HOLDOFF     = 2;

  logic              clk;
  logic              reset;
  logic [NIRQ-1:0]   mip;
  logic [NIRQ-1:0]   mie;
  logic [NIRQ-1:0]   mideleg;
  logic              statusMie;
  logic              statusSie;
  logic [1:0]        priv;
  logic              stallW;
  logic              exceptionM;
  logic              trapAckM;
  logic              mretM;
  logic              sretM;
  logic              intReqM;
  logic [CAUSEW-1:0] intCauseM;
  logic              intDelegateM;
  logic              schedBusyM;
`ifdef IRQ_TRAP_SCHEDULER_WFI_EN
  logic              wfiM;
  logic              wfiWakeM;
`endif

  int errors = 0;
  int checks = 0;

  // Model state: 0 = idle, 1 = requesting, 2 = holdoff
  int   mState  = 0;
  int   mBlock  = 0;
  int   mCause  = 0;
  logic mDeleg  = 1'b0;
  logic mWake   = 1'b0;

  irq_trap_scheduler #(
    .NIRQ(NIRQ), .CAUSEW(CAUSEW), .S_SUPPORTED(S_SUPPORTED), .HOLDOFF(HOLDOFF)
  ) dut (
    .clk(clk),
    .reset(reset),
    .MIP_REGW(mip),
    .MIE_REGW(mie),
    .MIDELEG_REGW(mideleg),
    .STATUS_MIE(statusMie),
    .STATUS_SIE(statusSie),
    .PrivilegeModeW(priv),
    .StallW(stallW),
    .ExceptionM(exceptionM),
    .TrapAckM(trapAckM),
    .mretM(mretM),
    .sretM(sretM),
`ifdef IRQ_TRAP_SCHEDULER_WFI_EN
    .WfiM(wfiM),
    .WfiWakeM(wfiWakeM),
`endif
    .IntReqM(intReqM),
    .IntCauseM(intCauseM),
    .IntDelegateM(intDelegateM),
    .SchedBusyM(schedBusyM)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Can interrupt i be taken right now, given the current CSR inputs?
  function automatic logic isEligible(int i);
    logic dlg;
    if (!(mip[i] && mie[i])) return 1'b0;
    dlg = (S_SUPPORTED != 0) && mideleg[i];
    if (!dlg) return (priv != 2'd3) || statusMie;
    return (priv == 2'd0) || (priv == 2'd1 && statusSie);
  endfunction

  // Walk the priority list; -1 when nothing is eligible.
  function automatic int pickIrq();
    int order[6] = '{11, 3, 7, 9, 1, 5};
    foreach (order[k]) if (isEligible(order[k])) return order[k];
    for (int i = NIRQ - 1; i >= 12; i--) if (isEligible(i)) return i;
    return -1;
  endfunction

  // Behavioural model of the scheduler, stepping once per clock.
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      mState <= 0;
      mBlock <= 0;
      mCause <= 0;
      mDeleg <= 1'b0;
      mWake  <= 1'b0;
    end else begin
`ifdef IRQ_TRAP_SCHEDULER_WFI_EN
      mWake <= wfiM && ((mip & mie) != '0);
`endif
      if (!stallW) begin
        if (mState == 0) begin
          if (mretM || sretM) begin
            mState <= 2;
            mBlock <= HOLDOFF;
          end else if (pickIrq() >= 0 && !exceptionM) begin
            mState <= 1;
            mCause <= pickIrq();
            mDeleg <= (S_SUPPORTED != 0) && mideleg[pickIrq()];
          end
        end else if (mState == 1) begin
          if (trapAckM && !exceptionM) begin
            mState <= 2;
            mBlock <= HOLDOFF;
          end else if (!trapAckM && !isEligible(mCause)) begin
            mState <= 0;
          end
        end else begin
          if (mretM || sretM) mBlock <= HOLDOFF;
          else if (mBlock - 1 == 0) mState <= 0;
          else mBlock <= mBlock - 1;
        end
      end
    end
  end

  // Per-cycle comparison of DUT outputs against the model.
  always @(negedge clk) begin
    checkOutput("cyc_req", {31'd0, intReqM}, {31'd0, mState == 1});
    checkOutput("cyc_busy", {31'd0, schedBusyM}, {31'd0, mState != 0});
    if (mState == 1) begin
      checkOutput("cyc_cause", 32'(intCauseM), 32'(mCause));
      checkOutput("cyc_deleg", {31'd0, intDelegateM}, {31'd0, mDeleg});
    end
`ifdef IRQ_TRAP_SCHEDULER_WFI_EN
    checkOutput("cyc_wake", {31'd0, wfiWakeM}, {31'd0, mWake});
`endif
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic applyStimulus(input logic [NIRQ-1:0] p, input logic [NIRQ-1:0] e,
                               input logic [NIRQ-1:0] d, input logic [1:0] pm,
                               input logic gm, input logic gs);
    mip       = p;
    mie       = e;
    mideleg   = d;
    priv      = pm;
    statusMie = gm;
    statusSie = gs;
  endtask

  // Ack anything outstanding, clear pending, and wait out the holdoff.
  task automatic returnIdle();
    trapAckM = 1'b1;
    mip      = '0;
    mie      = '0;
    tick(1);
    trapAckM = 1'b0;
    tick(HOLDOFF + 1);
  endtask

  typedef struct {
    logic [NIRQ-1:0] p;
    logic [NIRQ-1:0] e;
    logic [NIRQ-1:0] d;
    logic [1:0]      pm;
    logic            gm;
    logic            gs;
    logic            req;
    int              cause;
    logic            dlg;
  } vecT;

  vecT vecs[10];

  initial begin
    vecs[0] = '{12'hFFF, 12'hFFF, 12'h000, 2'd0, 1'b0, 1'b0, 1'b1, 11, 1'b0};
    vecs[1] = '{12'h222, 12'h222, 12'h000, 2'd0, 1'b0, 1'b0, 1'b1,  9, 1'b0};
    vecs[2] = '{12'h022, 12'h022, 12'h000, 2'd0, 1'b0, 1'b0, 1'b1,  1, 1'b0};
    vecs[3] = '{12'h020, 12'h020, 12'h020, 2'd1, 1'b0, 1'b1, 1'b1,  5, 1'b1};
    vecs[4] = '{12'h020, 12'h020, 12'h020, 2'd1, 1'b0, 1'b0, 1'b0,  0, 1'b0};
    vecs[5] = '{12'h020, 12'h020, 12'h020, 2'd0, 1'b0, 1'b0, 1'b1,  5, 1'b1};
    vecs[6] = '{12'h080, 12'h000, 12'h000, 2'd0, 1'b0, 1'b0, 1'b0,  0, 1'b0};
    vecs[7] = '{12'h808, 12'h808, 12'h800, 2'd3, 1'b1, 1'b1, 1'b1,  3, 1'b0};
    vecs[8] = '{12'h802, 12'h802, 12'h002, 2'd1, 1'b0, 1'b1, 1'b1, 11, 1'b0};
    vecs[9] = '{12'h0A0, 12'h0A0, 12'h080, 2'd1, 1'b0, 1'b0, 1'b1,  5, 1'b0};

    reset      = 1'b0;
    stallW     = 1'b0;
    exceptionM = 1'b0;
    trapAckM   = 1'b0;
    mretM      = 1'b0;
    sretM      = 1'b0;
`ifdef IRQ_TRAP_SCHEDULER_WFI_EN
    wfiM       = 1'b0;
`endif
    applyStimulus('0, '0, '0, 2'd3, 1'b0, 1'b0);
    tick(2);
    checkOutput("rst_req", {31'd0, intReqM}, 32'd0);
    checkOutput("rst_busy", {31'd0, schedBusyM}, 32'd0);
    checkOutput("rst_cause", 32'(intCauseM), 32'd0);
    checkOutput("rst_deleg", {31'd0, intDelegateM}, 32'd0);
    reset = 1'b1;
    tick(2);

    $display("[TB] basic request from U-mode, ack and holdoff");
    applyStimulus(12'h0A0, 12'h0A0, 12'h000, 2'd0, 1'b0, 1'b0);
    tick(1);
    checkOutput("t1_req", {31'd0, intReqM}, 32'd1);
    checkOutput("t1_cause", 32'(intCauseM), 32'd7);
    checkOutput("t1_deleg", {31'd0, intDelegateM}, 32'd0);
    trapAckM = 1'b1;
    mip      = '0;
    tick(1);
    trapAckM = 1'b0;
    checkOutput("t1_ack_req", {31'd0, intReqM}, 32'd0);
    checkOutput("t1_hold1", {31'd0, schedBusyM}, 32'd1);
    tick(1);
    checkOutput("t1_hold2", {31'd0, schedBusyM}, 32'd1);
    tick(1);
    checkOutput("t1_idle", {31'd0, schedBusyM}, 32'd0);

    $display("[TB] M-mode global enable and delegated interrupts in M");
    applyStimulus(12'h800, 12'h800, 12'h000, 2'd3, 1'b0, 1'b0);
    tick(3);
    checkOutput("t2_masked", {31'd0, intReqM}, 32'd0);
    statusMie = 1'b1;
    tick(1);
    checkOutput("t2_req", {31'd0, intReqM}, 32'd1);
    checkOutput("t2_cause", 32'(intCauseM), 32'd11);
    returnIdle();
    applyStimulus(12'h200, 12'h200, 12'h200, 2'd3, 1'b1, 1'b1);
    tick(3);
    checkOutput("t2_deleg_in_m", {31'd0, intReqM}, 32'd0);
    returnIdle();

    $display("[TB] withdrawal, no same-cycle re-arbitration, no preemption");
    applyStimulus(12'h028, 12'h028, 12'h000, 2'd0, 1'b0, 1'b0);
    tick(1);
    checkOutput("t3_cause3", 32'(intCauseM), 32'd3);
    mie = 12'h020;
    tick(1);
    checkOutput("t3_withdraw_req", {31'd0, intReqM}, 32'd0);
    checkOutput("t3_withdraw_busy", {31'd0, schedBusyM}, 32'd0);
    tick(1);
    checkOutput("t3_rearb_req", {31'd0, intReqM}, 32'd1);
    checkOutput("t3_rearb_cause", 32'(intCauseM), 32'd5);
    mip = 12'h820;
    mie = 12'h820;
    tick(2);
    checkOutput("t3_no_preempt", 32'(intCauseM), 32'd5);
    returnIdle();

    $display("[TB] ack that belongs to an exception");
    applyStimulus(12'h002, 12'h002, 12'h000, 2'd0, 1'b0, 1'b0);
    tick(1);
    trapAckM   = 1'b1;
    exceptionM = 1'b1;
    tick(1);
    checkOutput("t4_exc_req", {31'd0, intReqM}, 32'd1);
    checkOutput("t4_exc_cause", 32'(intCauseM), 32'd1);
    exceptionM = 1'b0;
    tick(1);
    checkOutput("t4_ack_req", {31'd0, intReqM}, 32'd0);
    checkOutput("t4_ack_busy", {31'd0, schedBusyM}, 32'd1);
    returnIdle();

    $display("[TB] xRET holdoff and reload");
    mretM = 1'b1;
    tick(1);
    mretM = 1'b0;
    checkOutput("t5_mret_busy", {31'd0, schedBusyM}, 32'd1);
    applyStimulus(12'h080, 12'h080, 12'h000, 2'd0, 1'b0, 1'b0);
    tick(1);
    sretM = 1'b1;
    tick(1);
    sretM = 1'b0;
    tick(1);
    checkOutput("t5_blocked", {31'd0, intReqM}, 32'd0);
    tick(1);
    checkOutput("t5_idle_busy", {31'd0, schedBusyM}, 32'd0);
    tick(1);
    checkOutput("t5_req_cause", 32'(intCauseM), 32'd7);
    returnIdle();

    $display("[TB] priority and delegation table");
    foreach (vecs[k]) begin
      applyStimulus(vecs[k].p, vecs[k].e, vecs[k].d, vecs[k].pm, vecs[k].gm, vecs[k].gs);
      tick(1);
      checkOutput($sformatf("vec%0d_req", k), {31'd0, intReqM}, {31'd0, vecs[k].req});
      if (vecs[k].req) begin
        checkOutput($sformatf("vec%0d_cause", k), 32'(intCauseM), 32'(vecs[k].cause));
        checkOutput($sformatf("vec%0d_deleg", k), {31'd0, intDelegateM}, {31'd0, vecs[k].dlg});
      end
      returnIdle();
    end

    $display("[TB] stall freezes state, then async reset mid-request");
    applyStimulus(12'h008, 12'h008, 12'h000, 2'd0, 1'b0, 1'b0);
    tick(1);
    stallW   = 1'b1;
    trapAckM = 1'b1;
    mie      = '0;
    for (int c = 0; c < 5; c++) begin
      tick(1);
      checkOutput($sformatf("t6_stall%0d_req", c), {31'd0, intReqM}, 32'd1);
      checkOutput($sformatf("t6_stall%0d_cause", c), 32'(intCauseM), 32'd3);
    end
    #2;
    reset = 1'b0;
    #1;
    checkOutput("t6_rst_req", {31'd0, intReqM}, 32'd0);
    checkOutput("t6_rst_cause", 32'(intCauseM), 32'd0);
    checkOutput("t6_rst_deleg", {31'd0, intDelegateM}, 32'd0);
    checkOutput("t6_rst_busy", {31'd0, schedBusyM}, 32'd0);
    stallW   = 1'b0;
    trapAckM = 1'b0;
    mip      = '0;
    tick(2);
    reset = 1'b1;
    tick(2);

`ifdef IRQ_TRAP_SCHEDULER_WFI_EN
    $display("[TB] stalled WFI wake");
    stallW = 1'b1;
    wfiM   = 1'b1;
    applyStimulus(12'h080, 12'h080, 12'h000, 2'd3, 1'b0, 1'b0);
    tick(1);
    checkOutput("t7_wake", {31'd0, wfiWakeM}, 32'd1);
    checkOutput("t7_noreq", {31'd0, intReqM}, 32'd0);
    stallW = 1'b0;
    wfiM   = 1'b0;
    mip    = '0;
    tick(2);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
